// File: rtl/snn_mac_pkg.sv
// Shared definitions for the spiking-network MAC input path: group size,
// default weight width, feeder state encoding and a width helper.
package snn_mac_pkg;

   // Spikes (and weights) carried by one MAC beat
   localparam int SPIKES_PER_MAC = 4;

   // Default synaptic weight width in bits
   localparam int W_WIDTH_DEF = 32;

   // Feeder FSM states
   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,   // waiting for a spike vector
      ST_SCAN    = 3'd1,   // looking at group grp, issuing a RAM read if nonzero
      ST_RD      = 3'd2,   // RAM data valid, capture beat payload
      ST_PRESENT = 3'd3,   // beat offered to the MAC
      ST_EMPTY   = 3'd4    // all-zero vector: single empty last beat
   } feeder_state_e;

   // Width of a group index; never below one bit so a single-group
   // configuration still has a real address port.
   function automatic int grp_w_f(input int num_grp);
      return (num_grp > 1) ? $clog2(num_grp) : 1;
   endfunction

endpackage

// File: rtl/grp_nonzero_scan.sv
// Combinational view of the held spike vector: which 4-spike groups carry
// any spike, whether the currently selected group does, its spikes, and
// whether any group above it is still nonzero (the "this is the last beat"
// decision is the inverse of that flag).
module grp_nonzero_scan
   import snn_mac_pkg::*;
#(
   parameter int NUM_INPUTS = 16,
   parameter int GRP_W      = 2
) (
   input  logic [NUM_INPUTS-1:0]     vec_i,
   input  logic [GRP_W-1:0]          grp_i,
   output logic                      cur_nz_o,
   output logic                      higher_nz_o,
   output logic [SPIKES_PER_MAC-1:0] cur_spikes_o
);

   localparam int NUM_GRP = NUM_INPUTS / SPIKES_PER_MAC;

   logic [NUM_GRP-1:0] grp_nz;

   // One OR-reduction per group
   generate
      for (genvar gi = 0; gi < NUM_GRP; gi++) begin : g_grp_or
         assign grp_nz[gi] = |vec_i[gi*SPIKES_PER_MAC +: SPIKES_PER_MAC];
      end
   endgenerate

   // Select the current group and OR together every group above it; the
   // index compare keeps out-of-range grp values harmless when NUM_GRP is
   // not a power of two.
   always_comb begin
      cur_nz_o     = 1'b0;
      higher_nz_o  = 1'b0;
      cur_spikes_o = '0;
      for (int g = 0; g < NUM_GRP; g++) begin
         if (GRP_W'(g) == grp_i) begin
            cur_nz_o     = grp_nz[g];
            cur_spikes_o = vec_i[g*SPIKES_PER_MAC +: SPIKES_PER_MAC];
         end
         if (GRP_W'(g) > grp_i) begin
            higher_nz_o = higher_nz_o | grp_nz[g];
         end
      end
   end

endmodule

// File: rtl/mac_spike_feeder.sv
// Producer side of the MAC input interface. Takes one presynaptic spike
// vector per timestep, walks it in 4-spike groups, fetches each nonzero
// group's weights from a synchronous weight RAM and hands the group to the
// MAC over valid/ready. All-zero groups are skipped; the final beat of a
// vector carries mac_last so the accumulator can close the timestep. An
// all-zero vector still yields one empty last beat.
module mac_spike_feeder
   import snn_mac_pkg::*;
#(
   parameter  int NUM_INPUTS = 16,
   parameter  int W_WIDTH    = W_WIDTH_DEF,
   localparam int NUM_GRP    = NUM_INPUTS / SPIKES_PER_MAC,
   localparam int GRP_W      = grp_w_f(NUM_GRP)
) (
   input  logic                                clk,
   input  logic                                rst_n,
   // upstream spike vector
   input  logic                                spike_vec_valid,
   input  logic [NUM_INPUTS-1:0]               spike_vec,
   output logic                                spike_vec_ready,
   // weight RAM read port (data one cycle after rd_en)
   output logic                                wmem_rd_en,
   output logic [GRP_W-1:0]                    wmem_addr,
   input  logic [SPIKES_PER_MAC*W_WIDTH-1:0]   wmem_rdata,
   // MAC beat interface
   output logic                                mac_valid,
   input  logic                                mac_ready,
   output logic [SPIKES_PER_MAC-1:0]           mac_spike_in,
   output logic [SPIKES_PER_MAC*W_WIDTH-1:0]   mac_weight,
   output logic                                mac_last
);

   localparam int WROW_W = SPIKES_PER_MAC * W_WIDTH;

   feeder_state_e state_q, state_d;

   logic [NUM_INPUTS-1:0]     vec_q, vec_d;
   logic [GRP_W-1:0]          grp_q, grp_d;
   logic [SPIKES_PER_MAC-1:0] spk_q, spk_d;
   logic [WROW_W-1:0]         weight_q, weight_d;
   logic                      last_q, last_d;

   logic                      cur_nz;
   logic                      higher_nz;
   logic [SPIKES_PER_MAC-1:0] cur_spikes;

   logic vec_hs;
   logic mac_hs;

   assign vec_hs = spike_vec_valid && spike_vec_ready;
   assign mac_hs = mac_valid && mac_ready;

   grp_nonzero_scan #(
      .NUM_INPUTS (NUM_INPUTS),
      .GRP_W      (GRP_W)
   ) u_scan (
      .vec_i        (vec_q),
      .grp_i        (grp_q),
      .cur_nz_o     (cur_nz),
      .higher_nz_o  (higher_nz),
      .cur_spikes_o (cur_spikes)
   );

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next-state: scan skips zero groups one per cycle, a nonzero group
   // costs one read cycle plus one capture cycle before it is presented.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (vec_hs) begin
               state_d = (spike_vec == '0) ? ST_EMPTY : ST_SCAN;
            end
         end
         ST_SCAN: begin
            if (cur_nz) begin
               state_d = ST_RD;
            end
         end
         ST_RD: begin
            state_d = ST_PRESENT;
         end
         ST_PRESENT: begin
            if (mac_ready) begin
               state_d = last_q ? ST_IDLE : ST_SCAN;
            end
         end
         ST_EMPTY: begin
            if (mac_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // FSM outputs: handshake strobes and the RAM read pulse
   always_comb begin
      spike_vec_ready = 1'b0;
      wmem_rd_en      = 1'b0;
      mac_valid       = 1'b0;
      case (state_q)
         ST_IDLE:    spike_vec_ready = 1'b1;
         ST_SCAN:    wmem_rd_en      = cur_nz;
         ST_PRESENT: mac_valid       = 1'b1;
         ST_EMPTY:   mac_valid       = 1'b1;
         default:    ;
      endcase
   end

   // The read address is simply the group being scanned; it only matters
   // while wmem_rd_en is high.
   assign wmem_addr = grp_q;

   // Datapath next-state: vector capture, group walk and beat payload.
   // Payload registers only change in IDLE (empty beat) and RD (real beat),
   // so they are naturally frozen while a beat waits for mac_ready.
   always_comb begin
      vec_d    = vec_q;
      grp_d    = grp_q;
      spk_d    = spk_q;
      weight_d = weight_q;
      last_d   = last_q;
      case (state_q)
         ST_IDLE: begin
            if (vec_hs) begin
               vec_d = spike_vec;
               grp_d = '0;
               if (spike_vec == '0) begin
                  spk_d    = '0;
                  weight_d = '0;
                  last_d   = 1'b1;
               end
            end
         end
         ST_SCAN: begin
            // a nonzero group always exists at or above grp here, so the
            // increment can never run past the top group
            if (!cur_nz) begin
               grp_d = grp_q + GRP_W'(1);
            end
         end
         ST_RD: begin
            spk_d    = cur_spikes;
            weight_d = wmem_rdata;
            last_d   = !higher_nz;
         end
         ST_PRESENT: begin
            if (mac_hs && !last_q) begin
               grp_d = grp_q + GRP_W'(1);
            end
         end
         default: ;
      endcase
   end

   // Datapath registers; reset drops any vector in flight
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vec_q    <= '0;
         grp_q    <= '0;
         spk_q    <= '0;
         weight_q <= '0;
         last_q   <= 1'b0;
      end else begin
         vec_q    <= vec_d;
         grp_q    <= grp_d;
         spk_q    <= spk_d;
         weight_q <= weight_d;
         last_q   <= last_d;
      end
   end

   assign mac_spike_in = spk_q;
   assign mac_weight   = weight_q;
   assign mac_last     = last_q;

endmodule
